// File: rtl/gpio_core_param.sv
// Parametrised GPIO register core: output/OE registers with atomic aliases,
// synchronised and debounced inputs, per-pin edge/level interrupts.
module gpio_core_param #(
  parameter int N      = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16,
  parameter int DB_RST = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] gpio_addr,
  input  logic              gpio_we,
  input  logic [31:0]       gpio_dat_i,
  output logic [31:0]       gpio_dat_o,
  output logic              gpio_inta_o,
  input  logic [N-1:0]      in_pad_i,
  output logic [N-1:0]      out_pad_o,
  output logic [N-1:0]      oen_padoe_o
);

  localparam logic [ADDR_W-1:0] A_IN    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_OUT   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_SET   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_TGL   = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_OE    = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_INTE  = ADDR_W'(8'h18);
  localparam logic [ADDR_W-1:0] A_PTRIG = ADDR_W'(8'h1C);
  localparam logic [ADDR_W-1:0] A_BOTH  = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] A_LEVEL = ADDR_W'(8'h24);
  localparam logic [ADDR_W-1:0] A_INTS  = ADDR_W'(8'h28);
  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(8'h2C);
  localparam logic [ADDR_W-1:0] A_DBCNT = ADDR_W'(8'h30);

  logic [N-1:0]     out_q,   out_d;
  logic [N-1:0]     oe_q,    oe_d;
  logic [N-1:0]     inte_q,  inte_d;
  logic [N-1:0]     ptrig_q, ptrig_d;
  logic [N-1:0]     both_q,  both_d;
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     ints_q,  ints_d;
  logic             gie_q,   gie_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  logic [N-1:0]     sync1_q, sync2_q;
  logic [N-1:0]     deb_q,   deb_d;
  logic [N-1:0]     dp_q;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [31:0]      dat_o_q, dat_o_d;

  logic [N-1:0]     wdat;
  logic [N-1:0]     ints_clr;
  logic [N-1:0]     evt;
  logic [CNT_W-1:0] db_thr;

  assign wdat = gpio_dat_i[N-1:0];

  // Register writes; the set/clear/toggle aliases operate on the current OUT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    out_d    = out_q;
    oe_d     = oe_q;
    inte_d   = inte_q;
    ptrig_d  = ptrig_q;
    both_d   = both_q;
    level_d  = level_q;
    gie_d    = gie_q;
    db_cnt_d = db_cnt_q;
    ints_clr = '0;
    if (gpio_we) begin
      case (gpio_addr)
        A_OUT:   out_d    = wdat;
        A_SET:   out_d    = out_q | wdat;
        A_CLR:   out_d    = out_q & ~wdat;
        A_TGL:   out_d    = out_q ^ wdat;
        A_OE:    oe_d     = wdat;
        A_INTE:  inte_d   = wdat;
        A_PTRIG: ptrig_d  = wdat;
        A_BOTH:  both_d   = wdat;
        A_LEVEL: level_d  = wdat;
        A_INTS:  ints_clr = wdat;
        A_CTRL:  gie_d    = gpio_dat_i[0];
        A_DBCNT: db_cnt_d = gpio_dat_i[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // A threshold of 0 behaves like 1: deb follows after one mismatching cycle.
  always_comb begin
    db_thr = (db_cnt_q == '0) ? '0 : db_cnt_q - CNT_W'(1);
    deb_d  = deb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= db_thr) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Level mode wins over BOTH, which wins over PTRIG edge polarity.
  always_comb begin
    evt = (level_q & ~(deb_q ^ ptrig_q))
        | (~level_q &  both_q & (deb_q ^ dp_q))
        | (~level_q & ~both_q &  ptrig_q &  deb_q & ~dp_q)
        | (~level_q & ~both_q & ~ptrig_q & ~deb_q &  dp_q);
    ints_d = (ints_q & ~ints_clr) | (inte_q & evt);
  end

  // Read mux uses current state, so a same-cycle write returns the old value.
  always_comb begin
    dat_o_d = '0;
    case (gpio_addr)
      A_IN:    dat_o_d[N-1:0]     = deb_q;
      A_OUT:   dat_o_d[N-1:0]     = out_q;
      A_OE:    dat_o_d[N-1:0]     = oe_q;
      A_INTE:  dat_o_d[N-1:0]     = inte_q;
      A_PTRIG: dat_o_d[N-1:0]     = ptrig_q;
      A_BOTH:  dat_o_d[N-1:0]     = both_q;
      A_LEVEL: dat_o_d[N-1:0]     = level_q;
      A_INTS:  dat_o_d[N-1:0]     = ints_q;
      A_CTRL:  dat_o_d[1:0]       = {|ints_q, gie_q};
      A_DBCNT: dat_o_d[CNT_W-1:0] = db_cnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (sys_rst) begin
      out_q    <= '0;
      oe_q     <= '0;
      inte_q   <= '0;
      ptrig_q  <= '0;
      both_q   <= '0;
      level_q  <= '0;
      ints_q   <= '0;
      gie_q    <= 1'b0;
      db_cnt_q <= CNT_W'(DB_RST);
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      dp_q     <= '0;
      dat_o_q  <= '0;
      // NOTE: the per-pin counter array is reset too, so a reset in the
      // middle of a debounce discards the partial count.
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      inte_q   <= inte_d;
      ptrig_q  <= ptrig_d;
      both_q   <= both_d;
      level_q  <= level_d;
      ints_q   <= ints_d;
      gie_q    <= gie_d;
      db_cnt_q <= db_cnt_d;
      sync1_q  <= in_pad_i;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      dp_q     <= deb_q;
      dat_o_q  <= dat_o_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gpio_dat_o  = dat_o_q;
  assign gpio_inta_o = gie_q & (|ints_q);
  assign out_pad_o   = out_q;
  assign oen_padoe_o = oe_q;

endmodule

// File: tb/tb_gpio_core_param.sv
// Bench for gpio_core_param: a cycle-level register/pin model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_gpio_core_param;

  localparam int DB_RST = 2;
  localparam logic [7:0] IDLE = 8'h34;

  logic        clk;
  logic        sys_rst;
  logic [7:0]  gpio_addr;
  logic        gpio_we;
  logic [31:0] gpio_dat_i;
  logic [31:0] gpio_dat_o;
  logic        gpio_inta_o;
  logic [31:0] in_pad;
  logic [31:0] out_pad;
  logic [31:0] oe_pad;

  logic [7:0]  a8;
  logic        we8;
  logic [31:0] d8;
  logic [31:0] q8;
  logic        inta8;
  logic [7:0]  pad8;
  logic [7:0]  out8;
  logic [7:0]  oe8;

  int n_checks = 0;
  int n_errors = 0;

  gpio_core_param #(.N(32), .ADDR_W(8), .CNT_W(16), .DB_RST(DB_RST)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .gpio_addr(gpio_addr), .gpio_we(gpio_we),
    .gpio_dat_i(gpio_dat_i), .gpio_dat_o(gpio_dat_o), .gpio_inta_o(gpio_inta_o),
    .in_pad_i(in_pad), .out_pad_o(out_pad), .oen_padoe_o(oe_pad)
  );

  gpio_core_param #(.N(8), .ADDR_W(8), .CNT_W(16), .DB_RST(0)) dut8 (
    .sys_clk(clk), .sys_rst(sys_rst), .gpio_addr(a8), .gpio_we(we8),
    .gpio_dat_i(d8), .gpio_dat_o(q8), .gpio_inta_o(inta8),
    .in_pad_i(pad8), .out_pad_o(out8), .oen_padoe_o(oe8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", what, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 32-pin instance ----------------
  logic [31:0] m_out, m_oe, m_inte, m_ptrig, m_both, m_level, m_ints;
  logic        m_gie;
  int          m_db;
  logic [31:0] m_s1, m_s2, m_deb, m_dp, m_rd;
  int          m_run [32];
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_deb;
      8'h04: return m_out;
      8'h14: return m_oe;
      8'h18: return m_inte;
      8'h1C: return m_ptrig;
      8'h20: return m_both;
      8'h24: return m_level;
      8'h28: return m_ints;
      8'h2C: return {30'b0, m_ints != 0, m_gie};
      8'h30: return 32'(m_db);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] evt, nxt_deb, clr;
    int need;
    if (sys_rst) begin
      {m_out, m_oe, m_inte, m_ptrig, m_both, m_level, m_ints} = '0;
      m_gie = 1'b0;
      m_db  = DB_RST;
      {m_s1, m_s2, m_deb, m_dp, m_rd} = '0;
      for (int i = 0; i < 32; i++) m_run[i] = 0;
      m_valid = 1'b1;
    end else begin
      m_rd = m_read(gpio_addr);
      for (int i = 0; i < 32; i++) begin
        if (m_level[i])      evt[i] = (m_deb[i] == m_ptrig[i]);
        else if (m_both[i])  evt[i] = (m_deb[i] != m_dp[i]);
        else if (m_ptrig[i]) evt[i] = (m_deb[i] == 1'b1 && m_dp[i] == 1'b0);
        else                 evt[i] = (m_deb[i] == 1'b0 && m_dp[i] == 1'b1);
      end
      need = (m_db == 0) ? 1 : m_db;
      nxt_deb = m_deb;
      for (int i = 0; i < 32; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          if (m_run[i] + 1 >= need) begin
            nxt_deb[i] = m_s2[i];
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_dp  = m_deb;
      m_deb = nxt_deb;
      m_s2  = m_s1;
      m_s1  = in_pad;
      clr = (gpio_we && gpio_addr == 8'h28) ? gpio_dat_i : 32'h0;
      m_ints = (m_ints & ~clr) | (m_inte & evt);
      if (gpio_we) begin
        case (gpio_addr)
          8'h04: m_out   = gpio_dat_i;
          8'h08: m_out   = m_out | gpio_dat_i;
          8'h0C: m_out   = m_out & ~gpio_dat_i;
          8'h10: m_out   = m_out ^ gpio_dat_i;
          8'h14: m_oe    = gpio_dat_i;
          8'h18: m_inte  = gpio_dat_i;
          8'h1C: m_ptrig = gpio_dat_i;
          8'h20: m_both  = gpio_dat_i;
          8'h24: m_level = gpio_dat_i;
          8'h2C: m_gie   = gpio_dat_i[0];
          8'h30: m_db    = int'(gpio_dat_i[15:0]);
          default: ;
        endcase
      end
    end
  end

  // Outputs settle after the rising edge; compare them on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_rdata", gpio_dat_o, m_rd);
      check("model_out_pad", out_pad, m_out);
      check("model_oe_pad", oe_pad, m_oe);
      check("model_inta", {31'b0, gpio_inta_o}, {31'b0, m_gie && (m_ints != 0)});
    end
  end

  // ---------------- stimulus helpers (called just after a falling edge) ----
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    gpio_addr = a; gpio_dat_i = d; gpio_we = 1'b1;
    @(negedge clk);
    gpio_we = 1'b0; gpio_addr = IDLE;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    gpio_addr = a; gpio_we = 1'b0;
    @(negedge clk);
    d = gpio_dat_o;
    gpio_addr = IDLE;
  endtask

  task automatic wr8(input logic [7:0] a, input logic [31:0] d);
    a8 = a; d8 = d; we8 = 1'b1;
    @(negedge clk);
    we8 = 1'b0; a8 = IDLE;
  endtask

  task automatic rd8(input logic [7:0] a, output logic [31:0] d);
    a8 = a; we8 = 1'b0;
    @(negedge clk);
    d = q8;
  endtask

  typedef struct { logic [7:0] a; logic [31:0] d; } vec_t;
  vec_t vecs [8] = '{
    '{8'h04, 32'hA5A5_5A5A}, '{8'h14, 32'h0F0F_0F0F}, '{8'h08, 32'h0000_FFFF},
    '{8'h0C, 32'hF000_000F}, '{8'h10, 32'hFFFF_FFFF}, '{8'h30, 32'h0001_0003},
    '{8'h20, 32'h0000_FFFF}, '{8'h34, 32'hDEAD_BEEF}
  };

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    sys_rst = 1'b1; gpio_we = 1'b0; gpio_addr = IDLE; gpio_dat_i = '0; in_pad = '0;
    we8 = 1'b0; a8 = IDLE; d8 = '0; pad8 = '0;
    idle(2);
    sys_rst = 1'b0;

    // Reset clears everything; DB_CNT returns to its reset value.
    wr(8'h04, 32'hFFFF_FFFF);
    check("out_before_rst", out_pad, 32'hFFFF_FFFF);
    wr(8'h14, 32'h0000_FFFF);
    wr(8'h2C, 32'h1);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check("rst_out_pad", out_pad, 32'h0);
    check("rst_oe_pad", oe_pad, 32'h0);
    check("rst_inta", {31'b0, gpio_inta_o}, 32'h0);
    for (int a = 0; a <= 8'h34; a += 4) begin
      rd(8'(a), r);
      check($sformatf("rst_read_%02h", a), r, (a == 8'h30) ? 32'(DB_RST) : 32'h0);
    end

    // Atomic set / clear / toggle.
    wr(8'h04, 32'h0000_00F0);
    wr(8'h08, 32'h0000_000F);
    check("set_out", out_pad, 32'h0000_00FF);
    wr(8'h0C, 32'h0000_0030);
    check("clr_out", out_pad, 32'h0000_00CF);
    wr(8'h10, 32'hFF00_00FF);
    check("tgl_out", out_pad, 32'hFF00_0030);
    rd(8'h08, r); check("rd_set_alias", r, 32'h0);
    rd(8'h0C, r); check("rd_clr_alias", r, 32'h0);
    rd(8'h10, r); check("rd_tgl_alias", r, 32'h0);
    rd(8'h04, r); check("rd_out_after_ops", r, 32'hFF00_0030);

    // Debounce with DB_CNT=4: a 3-cycle glitch is rejected.
    wr(8'h18, 32'h1);
    wr(8'h1C, 32'h1);
    wr(8'h30, 32'h4);
    in_pad[0] = 1'b1;
    idle(3);
    in_pad[0] = 1'b0;
    idle(8);
    rd(8'h00, r); check("glitch_in", r, 32'h0);
    rd(8'h28, r); check("glitch_ints", r, 32'h0);

    // Held high: deb rises 4 edges after sync2, IN visible one cycle later.
    gpio_addr = 8'h00;
    in_pad[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) check("db_in_cycle6", gpio_dat_o, 32'h0);
      if (k == 7) check("db_in_cycle7", gpio_dat_o, 32'h1);
    end
    rd(8'h28, r); check("db_rise_ints", r, 32'h1);
    in_pad[0] = 1'b0;
    idle(8);
    rd(8'h28, r); check("db_fall_no_int", r, 32'h1);
    wr(8'h28, 32'h1);
    rd(8'h28, r); check("db_ints_cleared", r, 32'h0);

    // Edge modes with DB_CNT=0.
    wr(8'h30, 32'h0);
    wr(8'h1C, 32'h1);
    wr(8'h20, 32'h4);
    wr(8'h18, 32'hF);
    wr(8'h2C, 32'h1);
    in_pad[1] = 1'b1;
    idle(5);
    wr(8'h28, 32'hF);
    rd(8'h28, r); check("edge_pre_ints", r, 32'h0);
    in_pad[0] = 1'b1;
    idle(3);
    check("rise_inta_T0p2", {31'b0, gpio_inta_o}, 32'h0);
    @(negedge clk);
    check("rise_inta_T0p3", {31'b0, gpio_inta_o}, 32'h1);
    rd(8'h28, r); check("rise_ints", r, 32'h1);
    in_pad[1] = 1'b0;
    idle(5);
    rd(8'h28, r); check("fall_ints", r, 32'h3);
    in_pad[2] = 1'b1;
    idle(5);
    rd(8'h28, r); check("both_rise_ints", r, 32'h7);
    wr(8'h28, 32'h4);
    rd(8'h28, r); check("both_cleared", r, 32'h3);
    in_pad[2] = 1'b0;
    idle(5);
    rd(8'h28, r); check("both_fall_ints", r, 32'h7);
    wr(8'h28, 32'h7);
    check("clr_inta", {31'b0, gpio_inta_o}, 32'h0);
    rd(8'h28, r); check("clr_ints", r, 32'h0);

    // Level mode: set wins over a same-cycle clear.
    wr(8'h1C, 32'h9);
    wr(8'h24, 32'h8);
    in_pad[3] = 1'b1;
    idle(5);
    rd(8'h28, r); check("level_ints", r, 32'h8);
    wr(8'h28, 32'h8);
    rd(8'h28, r); check("level_set_wins", r, 32'h8);
    in_pad[3] = 1'b0;
    idle(5);
    wr(8'h28, 32'h8);
    rd(8'h28, r); check("level_cleared", r, 32'h0);
    in_pad[3] = 1'b1;
    idle(5);
    wr(8'h2C, 32'h0);
    check("gie_off_inta", {31'b0, gpio_inta_o}, 32'h0);
    rd(8'h2C, r); check("ctrl_pending", r, 32'h2);
    in_pad[3] = 1'b0;
    wr(8'h24, 32'h0);
    wr(8'h28, 32'hFFFF_FFFF);
    idle(4);

    // Directed write vectors; every read is tracked by the model.
    foreach (vecs[i]) wr(vecs[i].a, vecs[i].d);
    for (int a = 0; a <= 8'h34; a += 4) rd(8'(a), r);
    rd(8'h04, r); check("vec_out", r, 32'hFA5A_000F);
    rd(8'h14, r); check("vec_oe", r, 32'h0F0F_0F0F);
    rd(8'h30, r); check("vec_dbcnt", r, 32'h3);
    gpio_addr = 8'h04; gpio_dat_i = 32'h1234_5678; gpio_we = 1'b1;
    @(negedge clk);
    gpio_we = 1'b0;
    check("rd_during_wr_old", gpio_dat_o, 32'hFA5A_000F);
    @(negedge clk);
    check("rd_after_wr_new", gpio_dat_o, 32'h1234_5678);
    gpio_addr = IDLE;

    // Width masking on the 8-pin instance.
    wr8(8'h04, 32'hFFFF_FFFF);
    check("w8_out_pad", {24'b0, out8}, 32'h0000_00FF);
    wr8(8'h14, 32'hFFFF_FFFF);
    wr8(8'h18, 32'hFFFF_FFFF);
    rd8(8'h04, r); check("w8_out", r, 32'h0000_00FF);
    rd8(8'h14, r); check("w8_oe", r, 32'h0000_00FF);
    rd8(8'h18, r); check("w8_inte", r, 32'h0000_00FF);
    rd8(8'h34, r); check("w8_unmapped", r, 32'h0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
